// File: rtl/adder_rr_scheduler.sv
// Round-robin front end that shares one pipelined adder between two requesters.
// Defining ADDER_SCHED_STATS_EN adds saturating per-requester grant counters.
module adder_rr_scheduler #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              cin0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic              cin1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_cin,
  output logic              add_vld,
  input  logic [DATA_W-1:0] add_sum,
  input  logic              add_cout,
  output logic              rsp_vld0,
  output logic              rsp_vld1,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_cout,
  output logic [2:0]        inflight
`ifdef ADDER_SCHED_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [7:0]        gcnt0,
  output logic [7:0]        gcnt1
`endif
);

  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] addA_q, addA_d;
  logic [DATA_W-1:0] addB_q, addB_d;
  logic              addCin_q, addCin_d;
  logic              addVld_q, addVld_d;
  logic              addId_q, addId_d;
  logic [LATENCY-1:0] tagVld_q, tagVld_d;
  logic [LATENCY-1:0] tagId_q, tagId_d;
  logic              rspVld0_q, rspVld0_d;
  logic              rspVld1_q, rspVld1_d;
  logic [DATA_W-1:0] rspSum_q, rspSum_d;
  logic              rspCout_q, rspCout_d;
  logic [2:0]        inflight_q, inflight_d;
  logic              gnt0Int, gnt1Int, grant, lastVld, lastId, rspAny;

  // ptr_q names the requester that wins a tie; grants are suppressed during reset.
  always_comb begin
    gnt0Int = 1'b0;
    gnt1Int = 1'b0;
    if (rst) begin
      if (req0 && (!req1 || !ptr_q)) gnt0Int = 1'b1;
      else if (req1)                  gnt1Int = 1'b1;
    end
  end

  assign grant   = gnt0Int | gnt1Int;
  assign lastVld = tagVld_q[LATENCY-1];
  assign lastId  = tagId_q[LATENCY-1];
  assign rspAny  = rspVld0_q | rspVld1_q;

  always_comb begin
    ptr_d     = ptr_q;
    addA_d    = addA_q;
    addB_d    = addB_q;
    addCin_d  = addCin_q;
    addVld_d  = grant;
    addId_d   = addId_q;
    if (gnt0Int) begin
      addA_d   = a0;
      addB_d   = b0;
      addCin_d = cin0;
      addId_d  = 1'b0;
      ptr_d    = 1'b1;
    end else if (gnt1Int) begin
      addA_d   = a1;
      addB_d   = b1;
      addCin_d = cin1;
      addId_d  = 1'b1;
      ptr_d    = 1'b0;
    end

    // The tag shadows the adder pipeline so each result finds its owner.
    tagVld_d    = tagVld_q;
    tagId_d     = tagId_q;
    tagVld_d[0] = addVld_q;
    tagId_d[0]  = addId_q;
    for (int i = 1; i < LATENCY; i++) begin
      tagVld_d[i] = tagVld_q[i-1];
      tagId_d[i]  = tagId_q[i-1];
    end

    rspVld0_d = lastVld & ~lastId;
    rspVld1_d = lastVld & lastId;
    rspSum_d  = rspSum_q;
    rspCout_d = rspCout_q;
    if (lastVld) begin
      rspSum_d  = add_sum;
      rspCout_d = add_cout;
    end

    inflight_d = inflight_q;
    case ({grant, rspAny})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= 1'b0;
      addA_q     <= '0;
      addB_q     <= '0;
      addCin_q   <= 1'b0;
      addVld_q   <= 1'b0;
      addId_q    <= 1'b0;
      tagVld_q   <= '0;
      tagId_q    <= '0;
      rspVld0_q  <= 1'b0;
      rspVld1_q  <= 1'b0;
      rspSum_q   <= '0;
      rspCout_q  <= 1'b0;
      inflight_q <= 3'd0;
    end else begin
      ptr_q      <= ptr_d;
      addA_q     <= addA_d;
      addB_q     <= addB_d;
      addCin_q   <= addCin_d;
      addVld_q   <= addVld_d;
      addId_q    <= addId_d;
      tagVld_q   <= tagVld_d;
      tagId_q    <= tagId_d;
      rspVld0_q  <= rspVld0_d;
      rspVld1_q  <= rspVld1_d;
      rspSum_q   <= rspSum_d;
      rspCout_q  <= rspCout_d;
      inflight_q <= inflight_d;
    end
  end

  assign gnt0     = gnt0Int;
  assign gnt1     = gnt1Int;
  assign add_a    = addA_q;
  assign add_b    = addB_q;
  assign add_cin  = addCin_q;
  assign add_vld  = addVld_q;
  assign rsp_vld0 = rspVld0_q;
  assign rsp_vld1 = rspVld1_q;
  assign rsp_sum  = rspSum_q;
  assign rsp_cout = rspCout_q;
  assign inflight = inflight_q;

`ifdef ADDER_SCHED_STATS_EN
  logic [7:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;

  // Clear wins over a same-cycle increment; counts stick at 255.
  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    if (stat_clr) begin
      gcnt0_d = 8'd0;
      gcnt1_d = 8'd0;
    end else begin
      if (gnt0Int && gcnt0_q != 8'hFF) gcnt0_d = gcnt0_q + 8'd1;
      if (gnt1Int && gcnt1_q != 8'hFF) gcnt1_d = gcnt1_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gcnt0_q <= 8'd0;
      gcnt1_q <= 8'd0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: directed cycle table plus random traffic
// against a queue-based reference model; the shared adder is modelled here.
module tb_adder_rr_scheduler;

  localparam int DATA_W  = 8;
  localparam int LATENCY = 2;

  logic clk, rst, req0, cin0, req1, cin1;
  logic [7:0] a0, b0, a1, b1;
  logic gnt0, gnt1, add_cin, add_vld, add_cout, rsp_vld0, rsp_vld1, rsp_cout;
  logic [7:0] add_a, add_b, add_sum, rsp_sum;
  logic [2:0] inflight;
  logic stat_clr;
`ifdef ADDER_SCHED_STATS_EN
  logic [7:0] gcnt0, gcnt1;
`endif

  adder_rr_scheduler #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_vld(add_vld),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_vld0(rsp_vld0), .rsp_vld1(rsp_vld1), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .inflight(inflight)
`ifdef ADDER_SCHED_STATS_EN
    , .stat_clr(stat_clr), .gcnt0(gcnt0), .gcnt1(gcnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pipelined adder the scheduler drives.
  logic [8:0] adderPipe [LATENCY];
  always_ff @(posedge clk) begin
    adderPipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    for (int i = 1; i < LATENCY; i++) adderPipe[i] <= adderPipe[i-1];
  end
  assign add_sum  = adderPipe[LATENCY-1][7:0];
  assign add_cout = adderPipe[LATENCY-1][8];

  typedef struct {
    logic rst;
    logic r0; logic [7:0] a0; logic [7:0] b0; logic c0;
    logic r1; logic [7:0] a1; logic [7:0] b1; logic c1;
    logic eg0; logic eg1; logic ev; logic er0; logic er1;
    logic [7:0] esum; logic ecout; logic [2:0] einf;
  } vecT;

  typedef struct {
    int gcyc; int due; bit id; logic [7:0] sum; bit cout;
  } opT;

  vecT vecs[$];
  opT  expQ[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  modelPtr = 1'b0;
  bit  prevGrant = 1'b0;
  bit  mg0, mg1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic q0, input logic [7:0] x0, input logic [7:0] y0,
                               input logic c0, input logic q1, input logic [7:0] x1,
                               input logic [7:0] y1, input logic c1);
    rst = r; req0 = q0; a0 = x0; b0 = y0; cin0 = c0;
    req1 = q1; a1 = x1; b1 = y1; cin1 = c1;
  endtask

  task automatic row(input logic r, input logic q0, input logic [7:0] x0, input logic [7:0] y0, input logic c0,
                     input logic q1, input logic [7:0] x1, input logic [7:0] y1, input logic c1,
                     input logic eg0, input logic eg1, input logic ev, input logic er0, input logic er1,
                     input logic [7:0] esum, input logic ecout, input logic [2:0] einf);
    vecT v;
    v = '{r, q0, x0, y0, c0, q1, x1, y1, c1, eg0, eg1, ev, er0, er1, esum, ecout, einf};
    vecs.push_back(v);
  endtask

  task automatic idle(input logic ev, input logic er0, input logic er1,
                      input logic [7:0] esum, input logic ecout, input logic [2:0] einf);
    row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev, er0, er1, esum, ecout, einf);
  endtask

  // Reference: spec rules over a queue of issued operations, each due LATENCY+2 cycles after its grant.
  task automatic modelCheck();
    bit both, er0, er1;
    int cnt;
    logic [8:0] full;
    while (expQ.size() > 0 && expQ[0].due < cyc) void'(expQ.pop_front());
    mg0 = 1'b0; mg1 = 1'b0;
    if (rst === 1'b1) begin
      both = req0 && req1;
      if (both) begin
        mg0 = (modelPtr == 1'b0);
        mg1 = (modelPtr == 1'b1);
      end else begin
        mg0 = req0;
        mg1 = req1;
      end
    end
    checkOutput("model_gnt0", gnt0, mg0);
    checkOutput("model_gnt1", gnt1, mg1);
    checkOutput("model_add_vld", add_vld, prevGrant);
    er0 = 1'b0; er1 = 1'b0;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      er0 = (expQ[0].id == 1'b0);
      er1 = (expQ[0].id == 1'b1);
    end
    checkOutput("model_rsp_vld0", rsp_vld0, er0);
    checkOutput("model_rsp_vld1", rsp_vld1, er1);
    if (er0 || er1) begin
      checkOutput("model_rsp_sum", rsp_sum, expQ[0].sum);
      checkOutput("model_rsp_cout", rsp_cout, expQ[0].cout);
    end
    cnt = 0;
    foreach (expQ[i]) if (expQ[i].gcyc < cyc) cnt++;
    checkOutput("model_inflight", inflight, cnt);
    if (rst !== 1'b1) begin
      expQ.delete();
      modelPtr = 1'b0;
      prevGrant = 1'b0;
    end else begin
      prevGrant = mg0 || mg1;
      if (mg0 || mg1) begin
        full = mg0 ? ({1'b0, a0} + {1'b0, b0} + {8'd0, cin0})
                   : ({1'b0, a1} + {1'b0, b1} + {8'd0, cin1});
        expQ.push_back('{cyc, cyc + LATENCY + 2, mg1, full[7:0], full[8]});
        modelPtr = mg0;
      end
    end
    cyc++;
  endtask

  task automatic finishCycle();
    modelCheck();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit p0, p1;
    logic [7:0] ra0, rb0, ra1, rb1;
    logic rc0, rc1, rr;
    stat_clr = 1'b0;

    row(1, 1,   1,   1, 0, 0,  0,  0, 0, 1, 0, 0, 0, 0,   0, 0, 0);
    idle(1, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0, 1);
    idle(0, 1, 0, 2, 0, 1);
    idle(0, 0, 0, 0, 0, 0);
    row(0, 1,  20,  20, 1, 1, 75, 75, 1, 0, 0, 0, 0, 0,   0, 0, 0);
    row(1, 1,  20,  20, 1, 1, 75, 75, 1, 1, 0, 0, 0, 0,   0, 0, 0);
    row(1, 1,  20,  20, 1, 1, 75, 75, 1, 0, 1, 1, 0, 0,   0, 0, 1);
    row(1, 1,  20,  20, 1, 1, 75, 75, 1, 1, 0, 1, 0, 0,   0, 0, 2);
    row(1, 1,  20,  20, 1, 1, 75, 75, 1, 0, 1, 1, 0, 0,   0, 0, 3);
    idle(1, 1, 0,  41, 0, 4);
    idle(0, 0, 1, 151, 0, 3);
    idle(0, 1, 0,  41, 0, 2);
    idle(0, 0, 1, 151, 0, 1);
    idle(0, 0, 0,   0, 0, 0);
    row(1, 0,   0,   0, 0, 1, 128, 128, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    row(1, 0,   0,   0, 0, 1, 200, 200, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    idle(1, 0, 0,   0, 0, 2);
    idle(0, 0, 0,   0, 0, 2);
    idle(0, 0, 1,   0, 1, 2);
    idle(0, 0, 1, 144, 1, 1);
    idle(0, 0, 0,   0, 0, 0);
    row(1, 1,   5,   6, 0, 0,  0,  0, 0, 1, 0, 0, 0, 0,   0, 0, 0);
    row(1, 1,   7,   8, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0,   0, 0, 1);
    row(1, 1,   9,   9, 1, 0,  0,  0, 0, 1, 0, 1, 0, 0,   0, 0, 2);
    row(0, 0,   0,   0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,   0, 0, 3);
    for (int i = 0; i < 6; i++) idle(0, 0, 0, 0, 0, 0);
    row(1, 1,   3,   4, 0, 1,  9,  9, 0, 1, 0, 0, 0, 0,   0, 0, 0);
    idle(1, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0, 1);
    idle(0, 1, 0, 7, 0, 1);
    idle(0, 0, 0, 0, 0, 0);
    row(1, 1,  10,   1, 0, 0,  0,  0, 0, 1, 0, 0, 0, 0,   0, 0, 0);
    row(1, 1,  20,   2, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0,   0, 0, 1);
    row(1, 1,  30,   3, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0,   0, 0, 2);
    row(1, 1,  40,   4, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0,   0, 0, 3);
    row(1, 1,  50,   5, 0, 0,  0,  0, 0, 1, 0, 1, 1, 0,  11, 0, 4);
    row(1, 1,  60,   6, 0, 0,  0,  0, 0, 1, 0, 1, 1, 0,  22, 0, 4);
    idle(1, 1, 0, 33, 0, 4);
    idle(0, 1, 0, 44, 0, 3);
    idle(0, 1, 0, 55, 0, 2);
    idle(0, 1, 0, 66, 0, 1);
    idle(0, 0, 0,  0, 0, 0);

    // Reset with both requests raised: nothing may be granted and every register clears.
    applyStimulus(0, 1, 8'hAA, 8'h55, 1, 1, 8'h11, 8'h22, 1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_gnt0", gnt0, 0);
    checkOutput("reset_gnt1", gnt1, 0);
    checkOutput("reset_add_vld", add_vld, 0);
    checkOutput("reset_add_a", add_a, 0);
    checkOutput("reset_add_b", add_b, 0);
    checkOutput("reset_add_cin", add_cin, 0);
    checkOutput("reset_rsp_vld0", rsp_vld0, 0);
    checkOutput("reset_rsp_vld1", rsp_vld1, 0);
    checkOutput("reset_rsp_sum", rsp_sum, 0);
    checkOutput("reset_rsp_cout", rsp_cout, 0);
    checkOutput("reset_inflight", inflight, 0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].r0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
                    vecs[i].r1, vecs[i].a1, vecs[i].b1, vecs[i].c1);
      @(negedge clk);
      checkOutput($sformatf("row%0d_gnt0", i), gnt0, vecs[i].eg0);
      checkOutput($sformatf("row%0d_gnt1", i), gnt1, vecs[i].eg1);
      checkOutput($sformatf("row%0d_add_vld", i), add_vld, vecs[i].ev);
      checkOutput($sformatf("row%0d_rsp_vld0", i), rsp_vld0, vecs[i].er0);
      checkOutput($sformatf("row%0d_rsp_vld1", i), rsp_vld1, vecs[i].er1);
      checkOutput($sformatf("row%0d_inflight", i), inflight, vecs[i].einf);
      if (vecs[i].er0 || vecs[i].er1) begin
        checkOutput($sformatf("row%0d_rsp_sum", i), rsp_sum, vecs[i].esum);
        checkOutput($sformatf("row%0d_rsp_cout", i), rsp_cout, vecs[i].ecout);
      end
      finishCycle();
    end

    // Random traffic: each requester holds its operands until granted; occasional resets.
    p0 = 0; p1 = 0;
    ra0 = 0; rb0 = 0; rc0 = 0; ra1 = 0; rb1 = 0; rc1 = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1;
        ra0 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        rb0 = 8'($urandom);
        rc0 = 1'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1;
        ra1 = 8'($urandom);
        rb1 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        rc1 = 1'($urandom);
      end
      rr = ($urandom_range(0, 99) != 0);
      applyStimulus(rr, p0, ra0, rb0, rc0, p1, ra1, rb1, rc1);
      @(negedge clk);
      finishCycle();
      if (mg0) p0 = 0;
      if (mg1) p1 = 0;
    end

`ifdef ADDER_SCHED_STATS_EN
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    finishCycle();
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1, 1, 8'(n), 8'd1, 0, 0, 0, 0, 0);
      @(negedge clk);
      finishCycle();
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("stats_gcnt0_sat", gcnt0, 255);
    checkOutput("stats_gcnt1_zero", gcnt1, 0);
    finishCycle();
    applyStimulus(1, 1, 8'd1, 8'd2, 0, 0, 0, 0, 0);
    stat_clr = 1'b1;
    @(negedge clk);
    finishCycle();
    stat_clr = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("stats_clr_priority", gcnt0, 0);
    finishCycle();
`endif

    repeat (8) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      finishCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Shares one pipelined 8-bit adder between two requesters. Each cycle it picks at most one requester by round-robin and registers that requester's operands into the adder. It tracks ownership of every in-flight operation with a tag pipeline and returns each sum/carry to the requester that issued it. It sits directly in front of the pipelined 8-bit adder and uses the same clock.

Parameters:
DATA_W, 8, operand and sum width.
LATENCY, 2, adder pipeline depth: cycles from operands valid at adder inputs to result valid at adder outputs (>=1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
req0  input  1  requester 0 has an operation pending; held until gnt0.
a0, b0  input  DATA_W  requester 0 operands.
cin0  input  1  requester 0 carry-in.
req1, a1, b1, cin1  input  1/DATA_W/DATA_W/1  requester 1, same meaning as requester 0.
gnt0, gnt1  output  1  combinational grant; operands are accepted at the clock edge that closes a grant cycle.
add_a, add_b  output  DATA_W  registered operands to the adder.
add_cin  output  1  registered carry-in to the adder.
add_vld  output  1  add_a/add_b/add_cin hold a live operation.
add_sum  input  DATA_W  adder sum output.
add_cout  input  1  adder carry-out.
rsp_vld0, rsp_vld1  output  1  one-cycle pulse: rsp_sum/rsp_cout belong to that requester.
rsp_sum  output  DATA_W  registered result.
rsp_cout  output  1  registered carry-out.
inflight  output  3  count of operations issued and not yet returned (0..LATENCY+2).

Behaviour:
- Reset (rst=0 at edge): add_a, add_b, add_cin, add_vld, rsp_vld0, rsp_vld1, rsp_sum, rsp_cout all 0; inflight=0; tag pipeline cleared; round-robin pointer points to requester 0.
- Arbitration (combinational):
  - Only one request high: grant it.
  - Both requests high: grant the requester the pointer names.
  - No requests: no grant.
  - gnt0 and gnt1 are never both high; both are 0 while rst=0.
- Pointer update: after each grant, the pointer moves to the other requester. With no grant it holds.
- Throughput: one issue per cycle, no stall. A lone requester holding req gets a grant every cycle.
- Issue: on a grant edge, load the winner's a/b/cin into add_a/add_b/add_cin and set add_vld=1. With no grant, add_vld=0 and the operand registers hold their values.
- Tag pipeline:
  - LATENCY stages of {valid, id}. Stage 0 loads {add_vld, id of the last winner}.
  - When the last stage is valid, capture add_sum and add_cout into rsp_sum and rsp_cout on the next edge, and pulse rsp_vld[id] for one cycle.
- Latency: grant in cycle t means add_vld=1 in t+1, adder result in t+1+LATENCY, rsp_vld in t+2+LATENCY (4 cycles at default LATENCY).
- Ordering: responses leave in issue order; each requester sees its own results in the order it issued them.
- Width: sum is modulo 2^DATA_W; the carry goes only to rsp_cout; no sign handling.
- inflight: +1 on each grant and -1 on each rsp_vld pulse. A simultaneous grant and response leaves it unchanged.
- Reset mid-operation: all in-flight operations are dropped. No rsp_vld pulse follows reset, even though the adder still holds stale data.
- Responses are not held: the requester must sample rsp_* in the cycle its rsp_vld pulses.

Optional Feature:
ADDER_SCHED_STATS_EN
- Defined: adds outputs gcnt0 and gcnt1, 8 bits each. They count grants per requester, saturate at 255, and clear on reset. Adds input stat_clr, which zeroes both counters synchronously and has priority over a same-cycle increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 alone with a0=1, b0=1, cin0=0: gnt0 in cycle t; rsp_vld0 in t+4 with rsp_sum=2, rsp_cout=0; inflight returns to 0.
- req0 and req1 both held for 4 cycles, (20,20,cin 1) and (75,75,cin 1): grants alternate 0,1,0,1. Results arrive in issue order: 41/cout 0 to req0, 151/cout 0 to req1.
- req1 alone with 128+128, cin 0: rsp_vld1 with rsp_sum=0, rsp_cout=1. Then 200+200, cin 0: rsp_sum=144, rsp_cout=1.
- req0 held continuously for 6 cycles: gnt0 every cycle; 6 consecutive rsp_vld0 pulses; inflight peaks at 4.
- Assert rst=0 with 3 operations in flight: next cycle add_vld=0 and inflight=0. No rsp_vld pulses occur for 6 cycles, and the first grant after reset goes to requester 0.
- With ADDER_SCHED_STATS_EN: 300 grants to req0 give gcnt0=255. stat_clr together with a grant gives gcnt0=0.
